// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 4-digit common-anode 7-segment scan controller
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   enable      1 = scan display, 0 = all segments/digits off
//   blank_lz    1 = leading-zero blanking
//   load_valid  load request (valid/ready handshake)
//   load_ready  shadow register empty (combinational)
//   load_value  four BCD nibbles, [15:12] thousands .. [3:0] units
//   load_dp     decimal-point enables, bit 3 thousands .. bit 0 units
//   num         registered segment drive, active-low, {a,b,c,d,e,f,g,dp}
//   com         registered digit select, active-low one-hot
//   frame_done  registered 1-cycle pulse after each frame boundary
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  load_dp,
    output logic [7:0]  num,
    output logic [3:0]  com,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [15:0]      r_act_val;
    logic [3:0]       r_act_dp;
    logic [15:0]      r_pend_val;
    logic [3:0]       r_pend_dp;
    logic             r_pend_full;
    logic [7:0]       r_num;
    logic [3:0]       r_com;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_boundary;
    logic             w_xfer;
    logic [3:0]       w_nib;
    logic             w_dp;
    logic             w_blank;
    logic [6:0]       w_seg;
    logic [3:0]       w_com;

    // Segments a..g, active-low; dp is appended separately.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign load_ready = !r_pend_full;
    assign w_xfer     = load_valid && load_ready;
    assign w_tick     = enable && (r_div == DIV_MAX);
    assign w_boundary = w_tick && (r_idx == 2'd3);

    always_comb begin
        w_nib   = 4'd0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        w_com   = 4'b1111;
        case (r_idx)
            2'd0: begin
                w_nib   = r_act_val[15:12];
                w_dp    = r_act_dp[3];
                w_blank = (r_act_val[15:12] == 4'd0);
                w_com   = 4'b0111;
            end
            2'd1: begin
                w_nib   = r_act_val[11:8];
                w_dp    = r_act_dp[2];
                w_blank = (r_act_val[15:8] == 8'd0);
                w_com   = 4'b1011;
            end
            2'd2: begin
                w_nib   = r_act_val[7:4];
                w_dp    = r_act_dp[1];
                w_blank = (r_act_val[15:4] == 12'd0);
                w_com   = 4'b1101;
            end
            default: begin
                w_nib   = r_act_val[3:0];
                w_dp    = r_act_dp[0];
                w_blank = 1'b0;
                w_com   = 4'b1110;
            end
        endcase
    end

    // A blanked digit still shows its decimal point.
    assign w_seg = (blank_lz && w_blank) ? 7'b1111111 : seg_of(w_nib);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div        <= '0;
            r_idx        <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (!enable) begin
                r_div <= '0;
                r_idx <= 2'd0;
            end else if (w_tick) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Boundary promotion and a new load are mutually exclusive: a load needs
    // the shadow empty, promotion needs it full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_act_val   <= 16'd0;
            r_act_dp    <= 4'd0;
            r_pend_val  <= 16'd0;
            r_pend_dp   <= 4'd0;
            r_pend_full <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_act_val   <= r_pend_val;
            r_act_dp    <= r_pend_dp;
            r_pend_full <= 1'b0;
        end else if (w_xfer) begin
            r_pend_val  <= load_value;
            r_pend_dp   <= load_dp;
            r_pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_num <= 8'hFF;
            r_com <= 4'b1111;
        end else if (enable) begin
            r_num <= {w_seg, ~w_dp};
            r_com <= w_com;
        end else begin
            r_num <= 8'hFF;
            r_com <= 4'b1111;
        end
    end

    assign num        = r_num;
    assign com        = r_com;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        blank_lz;
    logic        load_valid;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic        load_ready;
    logic [7:0]  num;
    logic [3:0]  com;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_dp    (load_dp),
        .num        (num),
        .com        (com),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        blz;
        logic [31:0] exp_num;  // thousands, hundreds, tens, units
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [3:0] com_of(input int k);
        case (k)
            0:       com_of = 4'b0111;
            1:       com_of = 4'b1011;
            2:       com_of = 4'b1101;
            default: com_of = 4'b1110;
        endcase
    endfunction

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("frame_timeout", 16'd0, 16'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("ready_timeout", 16'd0, 16'd1);
        load_value = v;
        load_dp    = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'h9F_25_0D_99};
        vecs[1] = '{16'h0007, 4'b0100, 1'b1, 32'hFF_FE_FF_1F};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFF_FF_FF_03};
        vecs[3] = '{16'h1A3F, 4'b1111, 1'b0, 32'h9E_FE_0C_FE};
        vecs[4] = '{16'h9876, 4'b1000, 1'b0, 32'h08_01_1F_41};
        vecs[5] = '{16'h5050, 4'b0001, 1'b1, 32'h49_03_49_02};

        reset      = 1'b0;
        enable     = 1'b1;
        blank_lz   = 1'b0;
        load_valid = 1'b0;
        load_value = 16'd0;
        load_dp    = 4'd0;

        // Reset state, then first edge after release.
        repeat (3) @(negedge clock);
        check("rst_num", {8'd0, num}, 16'hFF);
        check("rst_com", {12'd0, com}, 16'hF);
        check("rst_ready", {15'd0, load_ready}, 16'd1);
        check("rst_fd", {15'd0, frame_done}, 16'd0);
        reset = 1'b1;
        step();
        check("rel_com", {12'd0, com}, 16'h7);
        check("rel_num", {8'd0, num}, 16'h03);

        // Table-driven frames: load, wait for the promoting boundary, check 16 clocks.
        for (int v = 0; v < 6; v++) begin
            blank_lz = vecs[v].blz;
            do_load(vecs[v].val, vecs[v].dp);
            wait_frame();
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < DIV; j++) begin
                    step();
                    check($sformatf("v%0d_com_d%0d", v, k), {12'd0, com}, {12'd0, com_of(k)});
                    check($sformatf("v%0d_num_d%0d", v, k), {8'd0, num},
                          {8'd0, vecs[v].exp_num[31 - 8*k -: 8]});
                    check($sformatf("v%0d_fd", v), {15'd0, frame_done},
                          {15'd0, (k == 3 && j == DIV - 1)});
                end
            end
        end

        // Back-to-back loads: second held off until the boundary frees the shadow.
        blank_lz = 1'b0;
        do_load(16'h2222, 4'b0000);
        check("b2b_ready_after_load", {15'd0, load_ready}, 16'd0);
        load_value = 16'h3333;
        load_dp    = 4'b0000;
        load_valid = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (frame_done) begin
                    seen = 1'b1;
                    break;
                end
                check("b2b_ready_low", {15'd0, load_ready}, 16'd0);
            end
            if (!seen) check("b2b_timeout", 16'd0, 16'd1);
        end
        check("b2b_ready_back", {15'd0, load_ready}, 16'd1);
        step();
        load_valid = 1'b0;
        check("b2b_first_com", {12'd0, com}, 16'h7);
        check("b2b_first_num", {8'd0, num}, 16'h25);
        check("b2b_second_pending", {15'd0, load_ready}, 16'd0);
        wait_frame();
        step();
        check("b2b_second_com", {12'd0, com}, 16'h7);
        check("b2b_second_num", {8'd0, num}, 16'h0D);

        // Enable dropped mid-digit for 10 clocks, then restart at thousands.
        repeat (5) step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("dis_com", {12'd0, com}, 16'hF);
            check("dis_num", {8'd0, num}, 16'hFF);
            check("dis_fd", {15'd0, frame_done}, 16'd0);
        end
        enable = 1'b1;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            check("ren_com", {12'd0, com}, {12'd0, com_of(i / DIV)});
            check("ren_num", {8'd0, num}, 16'h0D);
            check("ren_fd", {15'd0, frame_done}, {15'd0, (i == 4 * DIV - 1)});
        end

        // Mid-operation reset discards a pending load.
        do_load(16'h4444, 4'b0000);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_num", {8'd0, num}, 16'hFF);
        check("mid_rst_com", {12'd0, com}, 16'hF);
        check("mid_rst_ready", {15'd0, load_ready}, 16'd1);
        check("mid_rst_fd", {15'd0, frame_done}, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("mid_rel_com", {12'd0, com}, 16'h7);
        check("mid_rel_num", {8'd0, num}, 16'h03);
        wait_frame();
        step();
        check("mid_discard_num", {8'd0, num}, 16'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
